// File: rtl/fwd_pkg.sv
// Shared constants for the forwarding / load-use hazard unit: operand select
// codes, load-use FSM states and default datapath widths.
package fwd_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  typedef logic [2:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE    = 3'd0;
  localparam fwd_sel_t FWD_MEM_ALU = 3'd1;
  localparam fwd_sel_t FWD_WB_ALU  = 3'd2;
  localparam fwd_sel_t FWD_WB_MEM  = 3'd3;
  localparam fwd_sel_t FWD_TMP_MEM = 3'd4;
  localparam fwd_sel_t FWD_TMP_ALU = 3'd5;

  typedef enum logic {
    LU_RUN   = 1'b0,
    LU_STALL = 1'b1
  } lu_state_t;

endpackage

// File: rtl/fwd_sel_pick.sv
// Priority encoder for one EX operand: MEM beats WB beats WB-temp, and a
// destination of x0 never produces a forward.
module fwd_sel_pick
  import fwd_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] i_rs,
  input  logic [AW-1:0] i_mem_rd,
  input  logic          i_mem_reg_write,
  input  logic [AW-1:0] i_wb_rd,
  input  logic          i_wb_reg_write,
  input  logic          i_wb_mem_to_reg,
  input  logic          i_tmp_valid,
  input  logic [AW-1:0] i_tmp_rd,
  input  logic          i_tmp_m2r,
  output fwd_sel_t      o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;
  logic w_tmp_hit;

  assign w_mem_hit = i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == i_rs);
  assign w_wb_hit  = i_wb_reg_write  && (i_wb_rd  != '0) && (i_wb_rd  == i_rs);
  assign w_tmp_hit = i_tmp_valid     && (i_tmp_rd != '0) && (i_tmp_rd == i_rs);

  always_comb begin
    o_sel = FWD_NONE;
    if (w_mem_hit)
      o_sel = FWD_MEM_ALU;
    else if (w_wb_hit)
      o_sel = i_wb_mem_to_reg ? FWD_WB_MEM : FWD_WB_ALU;
    else if (w_tmp_hit)
      o_sel = i_tmp_m2r ? FWD_TMP_MEM : FWD_TMP_ALU;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forward selects, load-use stall/bubble FSM and the WB-temp stage.
// Optional FWD_STATS_EN adds saturating forward / stall event counters.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int XLEN_P   = XLEN,
  parameter int REG_AW_P = REG_AW
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                pipe_hold,
  input  logic [REG_AW_P-1:0] id_rs1,
  input  logic [REG_AW_P-1:0] id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [REG_AW_P-1:0] ex_rs1,
  input  logic [REG_AW_P-1:0] ex_rs2,
  input  logic [REG_AW_P-1:0] ex_rd,
  input  logic                ex_mem_read,
  input  logic [REG_AW_P-1:0] mem_rd,
  input  logic                mem_reg_write,
  input  logic                mem_mem_read,
  input  logic [REG_AW_P-1:0] wb_rd,
  input  logic                wb_reg_write,
  input  logic [XLEN_P-1:0]   wb_alu_data,
  input  logic [XLEN_P-1:0]   wb_mem_data,
  input  logic                wb_mem_to_reg,
  output logic [2:0]          forward_signal1,
  output logic [2:0]          forward_signal2,
  output logic [XLEN_P-1:0]   wb_temp_alu_data,
  output logic [XLEN_P-1:0]   wb_temp_mem_data,
  output logic                stall_pc,
  output logic                stall_if_id,
  output logic                bubble_id_ex
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]         fwd_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  logic                r_tmp_valid;
  logic [REG_AW_P-1:0] r_tmp_rd;
  logic                r_tmp_m2r;
  logic [XLEN_P-1:0]   r_tmp_alu;
  logic [XLEN_P-1:0]   r_tmp_mem;

  lu_state_t r_state;
  lu_state_t w_state_next;
  logic      w_hazard;
  logic      w_lu_stall;

  // A MEM-stage load matching an EX source is an upstream protocol error;
  // the select still reports MEM, so the load flag plays no part here.
  logic w_unused_mem_read;
  assign w_unused_mem_read = mem_mem_read;

  fwd_sel_pick #(.AW(REG_AW_P)) u_pick_rs1 (
    .i_rs            (ex_rs1),
    .i_mem_rd        (mem_rd),
    .i_mem_reg_write (mem_reg_write),
    .i_wb_rd         (wb_rd),
    .i_wb_reg_write  (wb_reg_write),
    .i_wb_mem_to_reg (wb_mem_to_reg),
    .i_tmp_valid     (r_tmp_valid),
    .i_tmp_rd        (r_tmp_rd),
    .i_tmp_m2r       (r_tmp_m2r),
    .o_sel           (forward_signal1)
  );

  fwd_sel_pick #(.AW(REG_AW_P)) u_pick_rs2 (
    .i_rs            (ex_rs2),
    .i_mem_rd        (mem_rd),
    .i_mem_reg_write (mem_reg_write),
    .i_wb_rd         (wb_rd),
    .i_wb_reg_write  (wb_reg_write),
    .i_wb_mem_to_reg (wb_mem_to_reg),
    .i_tmp_valid     (r_tmp_valid),
    .i_tmp_rd        (r_tmp_rd),
    .i_tmp_m2r       (r_tmp_m2r),
    .o_sel           (forward_signal2)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tmp_valid <= 1'b0;
      r_tmp_rd    <= '0;
      r_tmp_m2r   <= 1'b0;
      r_tmp_alu   <= '0;
      r_tmp_mem   <= '0;
    end else if (!pipe_hold) begin
      r_tmp_valid <= wb_reg_write && (wb_rd != '0);
      r_tmp_rd    <= wb_rd;
      r_tmp_m2r   <= wb_mem_to_reg;
      r_tmp_alu   <= wb_alu_data;
      r_tmp_mem   <= wb_mem_data;
    end
  end

  assign wb_temp_alu_data = r_tmp_alu;
  assign wb_temp_mem_data = r_tmp_mem;

  assign w_hazard = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_state <= LU_RUN;
    else
      r_state <= w_state_next;
  end

  // The stall is asserted in the hazard cycle itself; LU_STALL only exists
  // to suppress a second bubble for the same load.
  always_comb begin
    w_state_next = r_state;
    w_lu_stall   = 1'b0;
    case (r_state)
      LU_RUN: begin
        w_lu_stall = w_hazard;
        if (!pipe_hold && w_hazard)
          w_state_next = LU_STALL;
      end
      LU_STALL: begin
        if (!pipe_hold)
          w_state_next = LU_RUN;
      end
      default: w_state_next = LU_RUN;
    endcase
  end

  assign stall_pc     = w_lu_stall;
  assign stall_if_id  = w_lu_stall;
  assign bubble_id_ex = w_lu_stall;

`ifdef FWD_STATS_EN
  logic [31:0] r_fwd_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_fwd_any;
  logic        w_lu_enter;

  assign w_fwd_any  = (forward_signal1 != FWD_NONE) || (forward_signal2 != FWD_NONE);
  assign w_lu_enter = (r_state == LU_RUN) && (w_state_next == LU_STALL);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fwd_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (!pipe_hold && w_fwd_any && (r_fwd_cnt != '1))
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
      if (w_lu_enter && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fwd_cnt   = r_fwd_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: vector table, directed multi-cycle
// sequences and a randomized run against a behavioural pipeline model.
module tb_fwd_hazard_unit;

  typedef struct {
    logic        hold;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_u1, id_u2;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_mr;
    logic [4:0]  mem_rd;
    logic        mem_we, mem_mr;
    logic [4:0]  wb_rd;
    logic        wb_we, wb_m2r;
    logic [63:0] wb_alu, wb_mem;
  } in_t;

  typedef struct {
    in_t        in;
    logic [2:0] f1, f2;
    logic       stall;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pipe_hold;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, mem_reg_write, mem_mem_read;
  logic        wb_reg_write, wb_mem_to_reg;
  logic [63:0] wb_alu_data, wb_mem_data;
  logic [2:0]  forward_signal1, forward_signal2;
  logic [63:0] wb_temp_alu_data, wb_temp_mem_data;
  logic        stall_pc, stall_if_id, bubble_id_ex;
`ifdef FWD_STATS_EN
  logic [31:0] fwd_cnt, stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // model state: the instruction that left WB last cycle, and whether the
  // current load already received its bubble
  logic        m_tv;
  logic [4:0]  m_trd;
  logic        m_tm2r;
  logic [63:0] m_talu, m_tmem;
  logic        m_bubbled;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk(clk), .rstn(rstn), .pipe_hold(pipe_hold),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_alu_data(wb_alu_data),
    .wb_mem_data(wb_mem_data), .wb_mem_to_reg(wb_mem_to_reg),
    .forward_signal1(forward_signal1), .forward_signal2(forward_signal2),
    .wb_temp_alu_data(wb_temp_alu_data), .wb_temp_mem_data(wb_temp_mem_data),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex)
`ifdef FWD_STATS_EN
    , .fwd_cnt(fwd_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic in_t zin();
    in_t v;
    v.hold = 0; v.id_rs1 = 0; v.id_rs2 = 0; v.id_u1 = 0; v.id_u2 = 0;
    v.ex_rs1 = 0; v.ex_rs2 = 0; v.ex_rd = 0; v.ex_mr = 0;
    v.mem_rd = 0; v.mem_we = 0; v.mem_mr = 0;
    v.wb_rd = 0; v.wb_we = 0; v.wb_m2r = 0; v.wb_alu = 0; v.wb_mem = 0;
    return v;
  endfunction

  task automatic drive(input in_t v);
    pipe_hold = v.hold;
    id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; id_use_rs1 = v.id_u1; id_use_rs2 = v.id_u2;
    ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_rd = v.ex_rd; ex_mem_read = v.ex_mr;
    mem_rd = v.mem_rd; mem_reg_write = v.mem_we; mem_mem_read = v.mem_mr;
    wb_rd = v.wb_rd; wb_reg_write = v.wb_we; wb_mem_to_reg = v.wb_m2r;
    wb_alu_data = v.wb_alu; wb_mem_data = v.wb_mem;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_stall(input string nm, input logic exp);
    chk({nm, ".stall_pc"}, {63'd0, stall_pc}, {63'd0, exp});
    chk({nm, ".stall_if_id"}, {63'd0, stall_if_id}, {63'd0, exp});
    chk({nm, ".bubble_id_ex"}, {63'd0, bubble_id_ex}, {63'd0, exp});
  endtask

  // Newest producer wins: walk MEM, WB, then the previous-WB instruction.
  function automatic logic [2:0] model_sel(input logic [4:0] rs, input in_t v);
    logic       pv[3];
    logic [4:0] prd[3];
    logic [2:0] pc[3];
    pv[0] = v.mem_we; prd[0] = v.mem_rd; pc[0] = 3'd1;
    pv[1] = v.wb_we;  prd[1] = v.wb_rd;  pc[1] = v.wb_m2r ? 3'd3 : 3'd2;
    pv[2] = m_tv;     prd[2] = m_trd;    pc[2] = m_tm2r ? 3'd4 : 3'd5;
    for (int i = 0; i < 3; i++)
      if (pv[i] && prd[i] != 0 && prd[i] == rs) return pc[i];
    return 3'd0;
  endfunction

  function automatic logic model_haz(input in_t v);
    return v.ex_mr && v.ex_rd != 0 &&
           ((v.id_u1 && v.id_rs1 == v.ex_rd) || (v.id_u2 && v.id_rs2 == v.ex_rd));
  endfunction

  task automatic model_reset();
    m_tv = 0; m_trd = 0; m_tm2r = 0; m_talu = 0; m_tmem = 0; m_bubbled = 0;
  endtask

  task automatic model_edge(input in_t v);
    if (rstn && !v.hold) begin
      m_bubbled = m_bubbled ? 1'b0 : model_haz(v);
      m_tv = v.wb_we && v.wb_rd != 0; m_trd = v.wb_rd; m_tm2r = v.wb_m2r;
      m_talu = v.wb_alu; m_tmem = v.wb_mem;
    end
  endtask

  task automatic apply(input in_t v);
    @(negedge clk);
    drive(v);
    #1;
  endtask

  task automatic tick(input in_t v);
    @(posedge clk);
    model_edge(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 0;
    drive(zin());
    @(posedge clk); @(posedge clk);
    model_reset();
    @(negedge clk);
    rstn = 1;
  endtask

  vec_t tbl[9];
  in_t  v;

  initial begin
    model_reset();
    drive(zin());
    #1;
    $display("tx reset: f1=%0d f2=%0d stall=%0b", forward_signal1, forward_signal2, stall_pc);
    chk("reset.f1", {61'd0, forward_signal1}, 0);
    chk("reset.f2", {61'd0, forward_signal2}, 0);
    chk_stall("reset", 0);
    chk("reset.tmp_alu", wb_temp_alu_data, 0);
    chk("reset.tmp_mem", wb_temp_mem_data, 0);
    do_reset();

    // table: pipeline held throughout, so the temp stage stays empty
    for (int i = 0; i < 9; i++) begin tbl[i].in = zin(); tbl[i].in.hold = 1; end
    tbl[0].in.mem_we = 1; tbl[0].in.mem_rd = 5; tbl[0].in.ex_rs1 = 5; tbl[0].in.ex_rs2 = 6;
    tbl[0].f1 = 1; tbl[0].f2 = 0; tbl[0].stall = 0;
    tbl[1].in.mem_we = 1; tbl[1].in.mem_rd = 5; tbl[1].in.wb_we = 1; tbl[1].in.wb_rd = 5;
    tbl[1].in.wb_m2r = 1; tbl[1].in.ex_rs1 = 5; tbl[1].in.ex_rs2 = 5;
    tbl[1].f1 = 1; tbl[1].f2 = 1; tbl[1].stall = 0;
    tbl[2].in.mem_rd = 5; tbl[2].in.wb_we = 1; tbl[2].in.wb_rd = 5; tbl[2].in.wb_m2r = 1;
    tbl[2].in.ex_rs1 = 5; tbl[2].in.ex_rs2 = 5;
    tbl[2].f1 = 3; tbl[2].f2 = 3; tbl[2].stall = 0;
    tbl[3].in.wb_we = 1; tbl[3].in.wb_rd = 5; tbl[3].in.ex_rs1 = 3; tbl[3].in.ex_rs2 = 5;
    tbl[3].f1 = 0; tbl[3].f2 = 2; tbl[3].stall = 0;
    tbl[4].in.mem_we = 1; tbl[4].in.wb_we = 1; tbl[4].in.wb_m2r = 1;
    tbl[4].f1 = 0; tbl[4].f2 = 0; tbl[4].stall = 0;
    tbl[5].in.ex_mr = 1; tbl[5].in.ex_rd = 7; tbl[5].in.id_rs2 = 7; tbl[5].in.id_u2 = 1;
    tbl[5].f1 = 0; tbl[5].f2 = 0; tbl[5].stall = 1;
    tbl[6].in.ex_mr = 1; tbl[6].in.ex_rd = 7; tbl[6].in.id_rs2 = 7; tbl[6].in.id_u2 = 0;
    tbl[6].f1 = 0; tbl[6].f2 = 0; tbl[6].stall = 0;
    tbl[7].in.ex_mr = 1; tbl[7].in.ex_rd = 0; tbl[7].in.id_rs1 = 0; tbl[7].in.id_u1 = 1;
    tbl[7].f1 = 0; tbl[7].f2 = 0; tbl[7].stall = 0;
    tbl[8].in.ex_mr = 0; tbl[8].in.ex_rd = 7; tbl[8].in.id_rs1 = 7; tbl[8].in.id_u1 = 1;
    tbl[8].f1 = 0; tbl[8].f2 = 0; tbl[8].stall = 0;
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].in);
      $display("tx vec%0d: f1=%0d f2=%0d stall=%0b", i, forward_signal1, forward_signal2, stall_pc);
      chk($sformatf("vec%0d.f1", i), {61'd0, forward_signal1}, {61'd0, tbl[i].f1});
      chk($sformatf("vec%0d.f2", i), {61'd0, forward_signal2}, {61'd0, tbl[i].f2});
      chk_stall($sformatf("vec%0d", i), tbl[i].stall);
      tbl[i].in.wb_alu = 64'hBAD0 + i;
      tick(tbl[i].in);
    end
    apply(zin());
    chk("held.tmp_alu", wb_temp_alu_data, 0);
    tick(zin());

    // load-use: ld x7 in EX, ID reads x7 as rs2
    v = zin(); v.ex_mr = 1; v.ex_rd = 7; v.id_rs2 = 7; v.id_u2 = 1; v.ex_rs1 = 2;
    apply(v); $display("tx lu.a: stall=%0b", stall_pc);
    chk_stall("lu.a", 1); tick(v);
    v = zin(); v.mem_rd = 7; v.mem_we = 1; v.mem_mr = 1; v.id_rs2 = 7; v.id_u2 = 1;
    v.ex_mr = 1; v.ex_rd = 7;  // even a matching EX load must not re-stall
    apply(v); $display("tx lu.b: stall=%0b", stall_pc);
    chk_stall("lu.b", 0); tick(v);
    v = zin(); v.ex_rs2 = 7; v.ex_rs1 = 1; v.wb_rd = 7; v.wb_we = 1; v.wb_m2r = 1;
    v.wb_mem = 64'h77; v.wb_alu = 64'h70;
    apply(v); $display("tx lu.c: f2=%0d stall=%0b", forward_signal2, stall_pc);
    chk("lu.c.f2", {61'd0, forward_signal2}, 3);
    chk_stall("lu.c", 0); tick(v);
    v = zin(); v.ex_rs1 = 7;
    apply(v); $display("tx lu.d: f1=%0d tmem=%0h", forward_signal1, wb_temp_mem_data);
    chk("lu.d.f1", {61'd0, forward_signal1}, 4);
    chk("lu.d.tmp_mem", wb_temp_mem_data, 64'h77); tick(v);

    // previous-WB ALU result forwarding
    v = zin(); v.wb_we = 1; v.wb_rd = 9; v.wb_alu = 64'hDEAD_BEEF;
    apply(v); tick(v);
    v = zin(); v.ex_rs1 = 9; v.ex_rs2 = 9;
    apply(v); $display("tx tmp: f1=%0d talu=%0h", forward_signal1, wb_temp_alu_data);
    chk("tmp.f1", {61'd0, forward_signal1}, 5);
    chk("tmp.f2", {61'd0, forward_signal2}, 5);
    chk("tmp.alu", wb_temp_alu_data, 64'hDEAD_BEEF); tick(v);

    // x0 written through WB into temp never forwards
    v = zin(); v.wb_we = 1; v.wb_rd = 0; v.mem_we = 1;
    apply(v); tick(v);
    v = zin(); v.ex_rs1 = 0; v.ex_rs2 = 0;
    apply(v); $display("tx x0: f1=%0d f2=%0d", forward_signal1, forward_signal2);
    chk("x0.f1", {61'd0, forward_signal1}, 0);
    chk("x0.f2", {61'd0, forward_signal2}, 0); tick(v);

    // hold during load-use, then async reset while stalled
    v = zin(); v.wb_we = 1; v.wb_rd = 3; v.wb_alu = 64'h1111; v.wb_mem = 64'h2222;
    apply(v); tick(v);
    v = zin(); v.hold = 1; v.ex_mr = 1; v.ex_rd = 4; v.id_rs1 = 4; v.id_u1 = 1;
    v.wb_we = 1; v.wb_rd = 6; v.wb_alu = 64'h9999; v.wb_mem = 64'h8888;
    for (int c = 0; c < 3; c++) begin
      apply(v); $display("tx hold%0d: stall=%0b talu=%0h", c, stall_pc, wb_temp_alu_data);
      chk_stall($sformatf("hold%0d", c), 1);
      chk($sformatf("hold%0d.tmp_alu", c), wb_temp_alu_data, 64'h1111);
      tick(v);
    end
    v.hold = 0;
    apply(v); chk_stall("hold.rel", 1); tick(v);
    apply(v); $display("tx lustall: stall=%0b talu=%0h", stall_pc, wb_temp_alu_data);
    chk_stall("lustall", 0);
    chk("lustall.tmp_alu", wb_temp_alu_data, 64'h9999);
    #1 rstn = 0;
    #1 $display("tx rst_mid: stall=%0b talu=%0h", stall_pc, wb_temp_alu_data);
    chk_stall("rst_mid", 1);
    chk("rst_mid.tmp_alu", wb_temp_alu_data, 0);
    chk("rst_mid.tmp_mem", wb_temp_mem_data, 0);
    drive(zin());
    #1 chk_stall("rst_mid.idle", 0);
    chk("rst_mid.f1", {61'd0, forward_signal1}, 0);
    chk("rst_mid.f2", {61'd0, forward_signal2}, 0);
    do_reset();

    // randomized run against the model
    for (int n = 0; n < 1500; n++) begin
      v = zin();
      v.hold = ($urandom_range(0, 4) == 0);
      v.id_rs1 = 5'($urandom_range(0, 3)); v.id_rs2 = 5'($urandom_range(0, 3));
      v.id_u1 = 1'($urandom); v.id_u2 = 1'($urandom);
      v.ex_rs1 = 5'($urandom_range(0, 3)); v.ex_rs2 = 5'($urandom_range(0, 3));
      v.ex_rd = 5'($urandom_range(0, 3)); v.ex_mr = ($urandom_range(0, 2) == 0);
      v.mem_rd = 5'($urandom_range(0, 3)); v.mem_we = 1'($urandom);
      v.wb_rd = 5'($urandom_range(0, 3)); v.wb_we = 1'($urandom); v.wb_m2r = 1'($urandom);
      v.wb_alu = {$urandom, $urandom}; v.wb_mem = {$urandom, $urandom};
      v.mem_mr = 1'($urandom);
      if (v.mem_we && v.mem_rd != 0 && (v.mem_rd == v.ex_rs1 || v.mem_rd == v.ex_rs2))
        v.mem_mr = 0;
      apply(v);
      $display("tx rnd%0d: f1=%0d f2=%0d stall=%0b", n, forward_signal1, forward_signal2, stall_pc);
      if (mem_mem_read && (forward_signal1 == 3'd1 || forward_signal2 == 3'd1))
        $display("warn rnd%0d: MEM-stage load selected for forwarding", n);
      chk($sformatf("rnd%0d.f1", n), {61'd0, forward_signal1}, {61'd0, model_sel(v.ex_rs1, v)});
      chk($sformatf("rnd%0d.f2", n), {61'd0, forward_signal2}, {61'd0, model_sel(v.ex_rs2, v)});
      chk_stall($sformatf("rnd%0d", n), !m_bubbled && model_haz(v));
      chk($sformatf("rnd%0d.tmp_alu", n), wb_temp_alu_data, m_talu);
      chk($sformatf("rnd%0d.tmp_mem", n), wb_temp_mem_data, m_tmem);
      tick(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
